pipe_control: RTL and testbench
===============================

# pipe_control

Pipelined main-control unit for the five-stage RISC-V core. It decodes the 32-bit instruction held in the ID stage into control bits, then carries them through ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards, inserts bubbles on stall and flush, and adds JAL/JALR decode with a PC+4 write-back select. It sits between the IF/ID register and the datapath stages, and drives the hazard stall for the PC and IF/ID registers.

## Interface
Parameters:
- HAZARD_EN, 1, 1 enables load-use detection; 0 ties STALL to 0.
- JAL_EN, 1, 1 decodes JAL/JALR; 0 treats them as illegal.

Ports:
- CLK  in  1  core clock, rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- INSTR  in  32  instruction in ID stage (from IF/ID register).
- ID_VALID  in  1  INSTR is a real instruction; 0 decodes as a bubble.
- FLUSH  in  1  branch/jump taken in EX; kill the ID instruction.
- HOLD  in  1  external freeze (memory wait); all pipeline registers keep their value.
- STALL  out  1  load-use hazard; the PC and IF/ID registers must not update (combinational).
- EX_BRANCH, EX_JUMP, EX_ALU_SRC  out  1 each  EX-stage control.
- EX_AUIPC_LUI  out  2  ALU A select: 0 = PC, 1 = zero, 2 = rs1.
- EX_ILLEGAL  out  1  instruction now in EX was undecodable.
- EX_MEM_READ, EX_MEM_WRITE, EX_REG_WRITE  out  1 each  EX-stage copies.
- EX_RD  out  5  EX destination register.
- MEM_MEM_READ, MEM_MEM_WRITE, MEM_REG_WRITE  out  1 each  MEM-stage control.
- MEM_RD  out  5  MEM destination register.
- WB_SEL  out  2  write-back source: 0 = ALU, 1 = memory, 2 = PC+4.
- WB_REG_WRITE  out  1  WB-stage control.
- WB_RD  out  5  WB destination register.

## Operation
Decode uses opcode INSTR[6:0] with no don't-care matching.
- R 0110011: ALU_SRC=0, AUIPC_LUI=2, REG_WRITE=1, WB_SEL=0.
- I-ALU 0010011: ALU_SRC=1, AUIPC_LUI=2, REG_WRITE=1, WB_SEL=0.
- LOAD 0000011: ALU_SRC=1, AUIPC_LUI=2, MEM_READ=1, REG_WRITE=1, WB_SEL=1.
- STORE 0100011: ALU_SRC=1, AUIPC_LUI=2, MEM_WRITE=1. MEM_READ=0.
- BRANCH 1100011: BRANCH=1, ALU_SRC=0, AUIPC_LUI=2.
- AUIPC 0010111: ALU_SRC=1, AUIPC_LUI=0, REG_WRITE=1, WB_SEL=0.
- LUI 0110111: ALU_SRC=1, AUIPC_LUI=1, REG_WRITE=1, WB_SEL=0.
- JAL 1101111: JUMP=1, ALU_SRC=1, AUIPC_LUI=0, REG_WRITE=1, WB_SEL=2.
- JALR 1100111: JUMP=1, ALU_SRC=1, AUIPC_LUI=2, REG_WRITE=1, WB_SEL=2.
- Any other opcode (or JAL/JALR with JAL_EN=0): all controls 0 and ILLEGAL=1.

Decode rules:
- Unlisted fields are 0.
- rd = INSTR[11:7]. REG_WRITE is forced to 0 when rd=0.
- Bubble: all control bits 0, RD=0, ILLEGAL=0.
- Register usage for hazard checks: R, STORE and BRANCH use rs1 (INSTR[19:15]) and rs2 (INSTR[24:20]). I-ALU, LOAD and JALR use rs1 only. LUI, AUIPC and JAL use neither.

Hazard rule:
- STALL = HAZARD_EN & ID_VALID & EX_MEM_READ & (EX_RD≠0) & (EX_RD matches a used rs) & ~FLUSH.

Per-edge update, evaluated in priority order:
1. RESET_N=0: all stage registers become bubbles.
2. HOLD=1: all registers keep their values. STALL is still computed.
3. Otherwise, MEM→WB and EX→MEM advance. ID→EX loads a bubble if FLUSH, STALL or ~ID_VALID is true; otherwise it loads the decoded ID controls.

## Timing
- Reset: every output is 0 on the first edge with RESET_N=0. STALL is 0 because EX is a bubble.
- Decode-to-EX latency is 1 cycle. EX→MEM is 1 cycle. MEM→WB is 1 cycle.
- STALL is combinational from INSTR and the EX registers, with no extra cycle. A load-use pair gives exactly one stall cycle: the load moves to MEM and EX holds a bubble, so STALL drops.
- FLUSH has priority over STALL (the STALL output is 0). FLUSH affects only the ID→EX register.
- HOLD freezes all three registers together. Releasing HOLD resumes with no lost or duplicated instruction.
- Reset asserted mid-stream clears all stages on that edge, including while HOLD=1.

## Test plan
- Reset: RESET_N=0 for 2 cycles with a random INSTR -> all outputs 0. Release, apply R-type add x3,x1,x2 -> next cycle EX_REG_WRITE=1, EX_RD=3, EX_AUIPC_LUI=2, WB_SEL=0 after 3 cycles.
- Full opcode sweep: each of the 9 opcodes plus 0x7F -> EX controls match the table above. 0x7F gives EX_ILLEGAL=1 with all other controls 0. With JAL_EN=0, JAL gives EX_ILLEGAL=1.
- Load-use: lw x5,0(x1) then add x6,x5,x2 -> STALL=1 for exactly one cycle and the bubble reaches EX. add x6,x0,x7 after the load -> STALL=0. Load into x0 -> STALL=0. With HAZARD_EN=0 -> STALL never asserts.
- Flush: FLUSH=1 while a STORE is in ID -> EX_MEM_WRITE=0 next cycle. FLUSH together with a load-use condition -> STALL=0 and a bubble is loaded.
- HOLD: assert HOLD for 3 cycles with the pipeline full (LOAD/STORE/R) -> all EX/MEM/WB outputs constant. Release -> the sequence continues unchanged.
- Write-back path: jal x1 -> WB_SEL=2 and WB_REG_WRITE=1 three cycles after decode. lw x4 -> WB_SEL=1 and WB_RD=4. addi x0,x0,1 -> WB_REG_WRITE=0.

Source files
------------

// File: rtl/pipe_control.sv
// Main-control decode for the five-stage core: ID decode registered into EX, then carried to MEM and WB (1 cycle/stage).
// hold freezes every stage register; stall (combinational load-use) blocks PC/IF-ID and turns the ID->EX load into a bubble.
module pipe_control #(
   parameter bit HAZARD_EN = 1'b1,
   parameter bit JAL_EN    = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] instr,
   input  logic        id_valid,
   input  logic        flush,
   input  logic        hold,
   output logic        stall,
   output logic        ex_branch,
   output logic        ex_jump,
   output logic        ex_alu_src,
   output logic [1:0]  ex_auipc_lui,
   output logic        ex_illegal,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic        ex_reg_write,
   output logic [4:0]  ex_rd,
   output logic        mem_mem_read,
   output logic        mem_mem_write,
   output logic        mem_reg_write,
   output logic [4:0]  mem_rd,
   output logic [1:0]  wb_sel,
   output logic        wb_reg_write,
   output logic [4:0]  wb_rd
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] A_PC   = 2'd0;
   localparam logic [1:0] A_ZERO = 2'd1;
   localparam logic [1:0] A_RS1  = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   typedef struct packed {
      logic       branch;
      logic       jump;
      logic       alu_src;
      logic [1:0] auipc_lui;
      logic       illegal;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic [4:0] rd;
   } ex_ctl_t;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic [4:0] rd;
   } mem_ctl_t;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] wb_sel;
      logic [4:0] rd;
   } wb_ctl_t;

   ex_ctl_t  dec;
   ex_ctl_t  ex_q;
   mem_ctl_t mem_q;
   wb_ctl_t  wb_q;
   logic     use_rs1;
   logic     use_rs2;
   logic     rs_match;

   wire [6:0] opcode = instr[6:0];
   wire [4:0] rs1    = instr[19:15];
   wire [4:0] rs2    = instr[24:20];

   logic unused_instr_bits;
   assign unused_instr_bits = &{1'b0, instr[31:25], instr[14:12]};

   always_comb begin
      dec     = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      case (opcode)
         OP_R: begin
            dec.auipc_lui = A_RS1;
            dec.reg_write = 1'b1;
            dec.wb_sel    = WB_ALU;
            use_rs1       = 1'b1;
            use_rs2       = 1'b1;
         end
         OP_IALU: begin
            dec.alu_src   = 1'b1;
            dec.auipc_lui = A_RS1;
            dec.reg_write = 1'b1;
            dec.wb_sel    = WB_ALU;
            use_rs1       = 1'b1;
         end
         OP_LOAD: begin
            dec.alu_src   = 1'b1;
            dec.auipc_lui = A_RS1;
            dec.mem_read  = 1'b1;
            dec.reg_write = 1'b1;
            dec.wb_sel    = WB_MEM;
            use_rs1       = 1'b1;
         end
         OP_STORE: begin
            dec.alu_src   = 1'b1;
            dec.auipc_lui = A_RS1;
            dec.mem_write = 1'b1;
            use_rs1       = 1'b1;
            use_rs2       = 1'b1;
         end
         OP_BRANCH: begin
            dec.branch    = 1'b1;
            dec.auipc_lui = A_RS1;
            use_rs1       = 1'b1;
            use_rs2       = 1'b1;
         end
         OP_AUIPC: begin
            dec.alu_src   = 1'b1;
            dec.auipc_lui = A_PC;
            dec.reg_write = 1'b1;
            dec.wb_sel    = WB_ALU;
         end
         OP_LUI: begin
            dec.alu_src   = 1'b1;
            dec.auipc_lui = A_ZERO;
            dec.reg_write = 1'b1;
            dec.wb_sel    = WB_ALU;
         end
         OP_JAL: begin
            if (JAL_EN) begin
               dec.jump      = 1'b1;
               dec.alu_src   = 1'b1;
               dec.auipc_lui = A_PC;
               dec.reg_write = 1'b1;
               dec.wb_sel    = WB_PC4;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OP_JALR: begin
            if (JAL_EN) begin
               dec.jump      = 1'b1;
               dec.alu_src   = 1'b1;
               dec.auipc_lui = A_RS1;
               dec.reg_write = 1'b1;
               dec.wb_sel    = WB_PC4;
               use_rs1       = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         default: dec.illegal = 1'b1;
      endcase
      dec.rd = instr[11:7];
      // x0 is hardwired, so a write to it is never a real write
      if (dec.rd == 5'd0) begin
         dec.reg_write = 1'b0;
      end
   end

   always_comb begin
      rs_match = (use_rs1 && (rs1 == ex_q.rd)) || (use_rs2 && (rs2 == ex_q.rd));
      stall    = HAZARD_EN && id_valid && ex_q.mem_read && (ex_q.rd != 5'd0) && rs_match && !flush;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (!hold) begin
         wb_q  <= '{reg_write: mem_q.reg_write, wb_sel: mem_q.wb_sel, rd: mem_q.rd};
         mem_q <= '{mem_read: ex_q.mem_read, mem_write: ex_q.mem_write, reg_write: ex_q.reg_write,
                    wb_sel: ex_q.wb_sel, rd: ex_q.rd};
         ex_q  <= (flush || stall || !id_valid) ? '0 : dec;
      end
   end

   assign ex_branch     = ex_q.branch;
   assign ex_jump       = ex_q.jump;
   assign ex_alu_src    = ex_q.alu_src;
   assign ex_auipc_lui  = ex_q.auipc_lui;
   assign ex_illegal    = ex_q.illegal;
   assign ex_mem_read   = ex_q.mem_read;
   assign ex_mem_write  = ex_q.mem_write;
   assign ex_reg_write  = ex_q.reg_write;
   assign ex_rd         = ex_q.rd;
   assign mem_mem_read  = mem_q.mem_read;
   assign mem_mem_write = mem_q.mem_write;
   assign mem_reg_write = mem_q.reg_write;
   assign mem_rd        = mem_q.rd;
   assign wb_sel        = wb_q.wb_sel;
   assign wb_reg_write  = wb_q.reg_write;
   assign wb_rd         = wb_q.rd;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: main instance plus JAL_EN=0 and HAZARD_EN=0 variants on the same stimulus.
module tb_pipe_control;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] instr;
   logic        id_valid;
   logic        flush;
   logic        hold;

   logic        stall, ex_branch, ex_jump, ex_alu_src, ex_illegal;
   logic [1:0]  ex_auipc_lui, wb_sel;
   logic        ex_mem_read, ex_mem_write, ex_reg_write;
   logic [4:0]  ex_rd, mem_rd, wb_rd;
   logic        mem_mem_read, mem_mem_write, mem_reg_write, wb_reg_write;

   wire [30:0]  nj_o;
   wire [30:0]  nh_o;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   always #5 clk = ~clk;

   pipe_control #(.HAZARD_EN(1'b1), .JAL_EN(1'b1)) u_dut (
      .clk(clk), .reset_n(reset_n), .instr(instr), .id_valid(id_valid), .flush(flush), .hold(hold),
      .stall(stall), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_src(ex_alu_src),
      .ex_auipc_lui(ex_auipc_lui), .ex_illegal(ex_illegal), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
      .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_reg_write(mem_reg_write),
      .mem_rd(mem_rd), .wb_sel(wb_sel), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd)
   );

   pipe_control #(.HAZARD_EN(1'b1), .JAL_EN(1'b0)) u_nojal (
      .clk(clk), .reset_n(reset_n), .instr(instr), .id_valid(id_valid), .flush(flush), .hold(hold),
      .stall(nj_o[0]), .ex_branch(nj_o[1]), .ex_jump(nj_o[2]), .ex_alu_src(nj_o[3]),
      .ex_auipc_lui(nj_o[5:4]), .ex_illegal(nj_o[6]), .ex_mem_read(nj_o[7]),
      .ex_mem_write(nj_o[8]), .ex_reg_write(nj_o[9]), .ex_rd(nj_o[14:10]),
      .mem_mem_read(nj_o[15]), .mem_mem_write(nj_o[16]), .mem_reg_write(nj_o[17]),
      .mem_rd(nj_o[22:18]), .wb_sel(nj_o[24:23]), .wb_reg_write(nj_o[25]), .wb_rd(nj_o[30:26])
   );

   pipe_control #(.HAZARD_EN(1'b0), .JAL_EN(1'b1)) u_nohaz (
      .clk(clk), .reset_n(reset_n), .instr(instr), .id_valid(id_valid), .flush(flush), .hold(hold),
      .stall(nh_o[0]), .ex_branch(nh_o[1]), .ex_jump(nh_o[2]), .ex_alu_src(nh_o[3]),
      .ex_auipc_lui(nh_o[5:4]), .ex_illegal(nh_o[6]), .ex_mem_read(nh_o[7]),
      .ex_mem_write(nh_o[8]), .ex_reg_write(nh_o[9]), .ex_rd(nh_o[14:10]),
      .mem_mem_read(nh_o[15]), .mem_mem_write(nh_o[16]), .mem_reg_write(nh_o[17]),
      .mem_rd(nh_o[22:18]), .wb_sel(nh_o[24:23]), .wb_reg_write(nh_o[25]), .wb_rd(nh_o[30:26])
   );

   wire [30:0] all_o = {wb_rd, wb_reg_write, wb_sel, mem_rd, mem_reg_write, mem_mem_write, mem_mem_read,
                        ex_rd, ex_reg_write, ex_mem_write, ex_mem_read, ex_illegal, ex_auipc_lui,
                        ex_alu_src, ex_jump, ex_branch, stall};
   wire [8:0]  ex_vec = {ex_branch, ex_jump, ex_alu_src, ex_auipc_lui, ex_illegal,
                         ex_mem_read, ex_mem_write, ex_reg_write};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'd0, rs2, rs1, 3'd0, rd, op};
   endfunction

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [6:0] sweep_op  [10];
   logic [8:0] sweep_exp [10];

   initial begin
      // {branch, jump, alu_src, auipc_lui[1:0], illegal, mem_read, mem_write, reg_write}
      sweep_op[0] = OP_R;      sweep_exp[0] = 9'b000_10_0001;
      sweep_op[1] = OP_IALU;   sweep_exp[1] = 9'b001_10_0001;
      sweep_op[2] = OP_LOAD;   sweep_exp[2] = 9'b001_10_0101;
      sweep_op[3] = OP_STORE;  sweep_exp[3] = 9'b001_10_0010;
      sweep_op[4] = OP_BRANCH; sweep_exp[4] = 9'b100_10_0000;
      sweep_op[5] = OP_AUIPC;  sweep_exp[5] = 9'b001_00_0001;
      sweep_op[6] = OP_LUI;    sweep_exp[6] = 9'b001_01_0001;
      sweep_op[7] = OP_JAL;    sweep_exp[7] = 9'b011_00_0001;
      sweep_op[8] = OP_JALR;   sweep_exp[8] = 9'b011_10_0001;
      sweep_op[9] = 7'h7F;     sweep_exp[9] = 9'b000_00_1000;

      reset_n  = 1'b0;
      instr    = $urandom;
      id_valid = 1'b1;
      flush    = 1'b0;
      hold     = 1'b0;
      step(2);
      check("reset_all_outputs", {1'b0, all_o}, 32'd0);

      // add x3,x1,x2 through all stages
      reset_n = 1'b1;
      instr   = mk(OP_R, 5'd3, 5'd1, 5'd2);
      step(1);
      check("add_ex_reg_write", ex_reg_write, 1);
      check("add_ex_rd", ex_rd, 3);
      check("add_ex_auipc_lui", ex_auipc_lui, 2);
      id_valid = 1'b0;
      step(2);
      check("add_wb_reg_write", wb_reg_write, 1);
      check("add_wb_rd", wb_rd, 3);
      check("add_wb_sel", wb_sel, 0);

      // opcode sweep, rd=5 rs1=1 rs2=2 never collides with the previous load's rd
      id_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         instr = mk(sweep_op[i], 5'd5, 5'd1, 5'd2);
         step(1);
         check($sformatf("sweep_ex_ctl_%0d", i), ex_vec, sweep_exp[i]);
         if (sweep_op[i] == OP_JAL || sweep_op[i] == OP_JALR) begin
            check($sformatf("nojal_illegal_%0d", i), nj_o[6], 1);
            check($sformatf("nojal_reg_write_%0d", i), nj_o[9], 0);
         end
      end
      check("sweep_ex_rd", ex_rd, 5);

      // load-use: lw x5,0(x1) ; add x6,x5,x2
      instr = mk(OP_LOAD, 5'd5, 5'd1, 5'd0);
      step(1);
      instr = mk(OP_R, 5'd6, 5'd5, 5'd2);
      #1;
      check("lu_stall_on", stall, 1);
      check("lu_nohaz_stall", nh_o[0], 0);
      step(1);
      check("lu_bubble_ex", {ex_reg_write, ex_mem_read, ex_rd}, 0);
      check("lu_load_in_mem", {mem_mem_read, mem_rd}, {1'b1, 5'd5});
      check("lu_stall_drops", stall, 0);
      step(1);
      check("lu_add_in_ex", {ex_reg_write, ex_rd}, {1'b1, 5'd6});

      // load then add x6,x0,x7: no dependency
      instr = mk(OP_LOAD, 5'd5, 5'd1, 5'd0);
      step(1);
      instr = mk(OP_R, 5'd6, 5'd0, 5'd7);
      #1;
      check("nodep_stall", stall, 0);

      // load into x0 then a reader of x0
      instr = mk(OP_LOAD, 5'd0, 5'd1, 5'd0);
      step(1);
      check("ldx0_reg_write", ex_reg_write, 0);
      instr = mk(OP_R, 5'd6, 5'd0, 5'd2);
      #1;
      check("ldx0_stall", stall, 0);

      // flush beats a load-use condition
      instr = mk(OP_LOAD, 5'd5, 5'd1, 5'd0);
      step(1);
      instr = mk(OP_R, 5'd6, 5'd5, 5'd2);
      flush = 1'b1;
      #1;
      check("flush_lu_stall", stall, 0);
      step(1);
      check("flush_lu_bubble", {ex_reg_write, ex_mem_read, ex_rd}, 0);

      // flush of a store in ID
      instr = mk(OP_STORE, 5'd9, 5'd2, 5'd3);
      step(1);
      check("flush_store_mw", ex_mem_write, 0);
      flush = 1'b0;

      // fill LOAD x4 / STORE / add x7, then hold for 3 cycles
      instr = mk(OP_LOAD, 5'd4, 5'd1, 5'd0);
      step(1);
      instr = mk(OP_STORE, 5'd9, 5'd2, 5'd3);
      step(1);
      instr = mk(OP_R, 5'd7, 5'd1, 5'd2);
      step(1);
      hold  = 1'b1;
      instr = mk(OP_LOAD, 5'd8, 5'd1, 5'd0);
      for (int c = 0; c < 3; c++) begin
         step(1);
         check($sformatf("hold_frozen_%0d", c),
               {ex_rd, ex_reg_write, mem_mem_write, mem_rd, wb_sel, wb_rd, wb_reg_write},
               {5'd7, 1'b1, 1'b1, 5'd9, 2'd1, 5'd4, 1'b1});
      end
      hold = 1'b0;
      step(1);
      check("hold_release_ex", {ex_mem_read, ex_rd}, {1'b1, 5'd8});
      check("hold_release_mem", {mem_reg_write, mem_rd}, {1'b1, 5'd7});
      check("hold_release_wb", {wb_reg_write, wb_rd}, {1'b0, 5'd9});

      // jal x1: PC+4 write-back three edges after decode
      instr = mk(OP_JAL, 5'd1, 5'd0, 5'd0);
      step(1);
      id_valid = 1'b0;
      step(2);
      check("jal_wb", {wb_sel, wb_reg_write, wb_rd}, {2'd2, 1'b1, 5'd1});

      // addi x0,x0,1
      id_valid = 1'b1;
      instr    = mk(OP_IALU, 5'd0, 5'd0, 5'd0) | 32'h0010_0000;
      step(1);
      id_valid = 1'b0;
      step(2);
      check("addi_x0_wb_reg_write", wb_reg_write, 0);

      // reset wins over hold mid-stream
      id_valid = 1'b1;
      instr    = mk(OP_R, 5'd3, 5'd1, 5'd2);
      step(1);
      hold    = 1'b1;
      reset_n = 1'b0;
      step(1);
      check("reset_under_hold", {1'b0, all_o}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
